// File: rtl/uart_pkg.sv
// Shared UART constants: frame layout, FSM state encoding and counter sizing helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int FRAME_W              = 12;
  localparam int START_POS            = 11;
  localparam int DATA_MSB             = 10;
  localparam int DATA_LSB             = 3;
  localparam int PAR_POS              = 2;
  localparam int STOP_MSB             = 1;
  localparam int STOP_LSB             = 0;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int BIT_CNT_W            = $clog2(FRAME_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } uart_state_e;

  // A count range of 1 still needs a one-bit register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
// Held at zero while disabled so every enabled run starts a fresh bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int               CNT_W   = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    if (!en || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame serialiser: accepts a pre-assembled 12-bit frame on valid/ready and
// shifts it out MSB first on a registered tx line, CLKS_PER_BIT clocks per bit.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic IDLE_LVL     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  uart_state_e          state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == SHIFT),
    .bit_tick(bit_tick)
  );

  // NOTE: every next-state signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = IDLE_LVL;
        if (frame_valid) begin
          shreg_d   = frame_in;
          bit_cnt_d = BIT_CNT_W'(FRAME_W - 1);
          tx_d      = frame_in[START_POS];
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q != '0) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
            tx_d      = shreg_q[FRAME_W-2];
          end else begin
            state_d = IDLE;
            tx_d    = IDLE_LVL;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LVL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign frame_ready = (state_q == IDLE);
  assign busy        = (state_q == SHIFT);
  assign tx          = tx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: dut0 runs at 4 clocks/bit, dut1 at 1 clock/bit.
// Stimulus pushes the expected per-cycle tx trace; per-DUT monitors pop and compare.
module tb_uart_frame_tx;

  localparam int NDUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] frame_in    [NDUT];
  logic        frame_valid [NDUT];
  logic        frame_ready [NDUT];
  logic        tx          [NDUT];
  logic        busy        [NDUT];
  logic        done        [NDUT];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit exp_q     [NDUT][$];
  int exp_done  [NDUT];
  int seen_done [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpb(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int C = (g == 0) ? 4 : 1;

    uart_frame_tx #(
      .CLKS_PER_BIT(C),
      .IDLE_LVL    (1'b1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_in   (frame_in[g]),
      .frame_valid(frame_valid[g]),
      .frame_ready(frame_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );

    int   acc_cyc   = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    bit   exp_bit;

    always @(negedge clk) begin
      if (rst) begin
        busy_prev <= 1'b0;
        done_prev <= 1'b0;
      end else begin
        if (busy[g]) begin
          if (!busy_prev) acc_cyc <= cyc;
          check("tx_pending", g, exp_q[g].size() > 0, 1);
          if (exp_q[g].size() > 0) begin
            exp_bit = exp_q[g].pop_front();
            check("tx_bit", g, tx[g], exp_bit);
          end
          check("ready_in_shift", g, frame_ready[g], 0);
        end else begin
          check("tx_idle", g, tx[g], 1);
          check("ready_in_idle", g, frame_ready[g], 1);
        end
        if (done[g]) begin
          seen_done[g] <= seen_done[g] + 1;
          check("done_time", g, cyc - acc_cyc, 12 * C);
          check("done_busy", g, busy[g], 0);
        end
        if (done_prev) check("done_one_cycle", g, done[g], 0);
        busy_prev <= busy[g];
        done_prev <= done[g];
      end
    end
  end

  task automatic push_frame(input int g, input logic [11:0] f);
    for (int n = 11; n >= 0; n--) begin
      for (int k = 0; k < cpb(g); k++) exp_q[g].push_back(f[n]);
    end
    exp_done[g]++;
  endtask

  // Drives the frame at a negedge while ready, returns right after the accept edge.
  task automatic issue(input int g, input logic [11:0] f);
    int t;
    t = 0;
    @(negedge clk);
    while (!frame_ready[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", g, frame_ready[g], 1);
    frame_in[g]    = f;
    frame_valid[g] = 1'b1;
    push_frame(g, f);
    @(posedge clk);
  endtask

  task automatic wait_done(input int g, input int bound);
    int t;
    t = 0;
    while (t < bound) begin
      @(negedge clk);
      if (done[g]) break;
      t++;
    end
    check("done_seen", g, done[g], 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      frame_in[g]    = '0;
      frame_valid[g] = 1'b0;
      exp_done[g]    = 0;
      seen_done[g]   = 0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("rst_tx", g, tx[g], 1);
      check("rst_ready", g, frame_ready[g], 1);
      check("rst_busy", g, busy[g], 0);
      check("rst_done", g, done[g], 0);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single frame 0xD28: 1,1,0,1,0,0,1,0,1,0,0,0.
    issue(0, 12'hD28);
    @(negedge clk);
    frame_valid[0] = 1'b0;
    wait_done(0, 100);
    repeat (3) @(negedge clk);

    // Back-to-back with valid held: one idle cycle, then 0x9FC.
    issue(0, 12'hD28);
    @(negedge clk);
    frame_in[0] = 12'h9FC;
    push_frame(0, 12'h9FC);
    wait_done(0, 100);
    @(negedge clk);
    check("b2b_accept", 0, busy[0], 1);
    check("b2b_first_bit", 0, tx[0], 1);
    frame_valid[0] = 1'b0;
    wait_done(0, 100);
    repeat (3) @(negedge clk);

    // Inputs are ignored while shifting.
    issue(0, 12'hD28);
    @(negedge clk);
    frame_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    frame_in[0]    = 12'hFFF;
    frame_valid[0] = 1'b1;
    @(negedge clk);
    check("ignored_ready", 0, frame_ready[0], 0);
    frame_valid[0] = 1'b0;
    wait_done(0, 100);
    repeat (3) @(negedge clk);
    check("no_extra_accept", 0, busy[0], 0);

    // Reset in the middle of a data bit discards the frame without a done pulse.
    issue(0, 12'hD28);
    @(negedge clk);
    frame_valid[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_tx", 0, tx[0], 1);
    check("rst_async_busy", 0, busy[0], 0);
    check("rst_async_done", 0, done[0], 0);
    exp_q[0].delete();
    exp_done[0]--;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, 12'h800);
    @(negedge clk);
    frame_valid[0] = 1'b0;
    wait_done(0, 100);

    // One clock per bit.
    issue(1, 12'hAAA);
    @(negedge clk);
    frame_valid[1] = 1'b0;
    wait_done(1, 50);
    repeat (5) @(negedge clk);

    for (int g = 0; g < NDUT; g++) begin
      check("done_count", g, seen_done[g], exp_done[g]);
      check("queue_drained", g, exp_q[g].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Serialises the 12-bit UART frame produced by the frame-assembly stage (start, data[7:0], parity, stop[1:0]) onto a single tx line. Each bit is held for CLKS_PER_BIT clocks. Bits go out from frame[11] down to frame[0]. It sits directly downstream of the frame builder and accepts one frame per valid/ready handshake. The block does not interpret field polarities; it transmits exactly the bits it is given.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 1..65535
FRAME_W, 12, frame width in bits; fixed to the package constant
IDLE_LVL, 1'b1, level driven on tx when not transmitting

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
frame_in  input  FRAME_W  frame to send; bit 11 = start, 10:3 = data, 2 = parity, 1:0 = stop
frame_valid  input  1  frame_in is valid
frame_ready  output  1  block can accept a frame (high only in IDLE)
tx  output  1  serial output, registered
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse after the last bit period completes

Behaviour:
- Clocking and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state = IDLE, tx = IDLE_LVL, frame_ready = 1, busy = 0, done = 0, shift register = 0, bit counter = 0, baud counter = 0.
- FSM states:
  - IDLE: frame_ready = 1; tx = IDLE_LVL.
  - SHIFT: frame_ready = 0, busy = 1.
- Accept: on a rising edge with frame_valid && frame_ready:
  - load the shift register with frame_in;
  - bit counter = FRAME_W-1, baud counter = 0;
  - go to SHIFT;
  - tx = frame_in[11], registered at that same edge (edge E0).
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1. bit_tick asserts when the count = CLKS_PER_BIT-1.
  - On bit_tick with bit counter > 0: shift left, decrement the bit counter, tx = next MSB.
  - Bit n (0 = frame[11]) is on tx from edge E0+n*CLKS_PER_BIT to E0+(n+1)*CLKS_PER_BIT.
- Completion:
  - On bit_tick with bit counter = 0, at edge E0+FRAME_W*CLKS_PER_BIT: go to IDLE, tx = IDLE_LVL, done = 1 for exactly one cycle, frame_ready = 1.
- Back-to-back frames:
  - If frame_valid stays high, the next frame is accepted at the edge after done (E0+FRAME_W*CLKS_PER_BIT+1).
  - The line therefore idles for exactly one clock between frames.
- Ignored inputs:
  - frame_in and frame_valid are ignored during SHIFT; there is no buffering.
  - frame_in is sampled only at the accept edge.
- CLKS_PER_BIT = 1: bit_tick is asserted every cycle; one bit per clock.
- Reset mid-frame: tx returns to IDLE_LVL immediately (asynchronously). The frame is discarded and no done pulse is produced. The first accept after reset release behaves as from power-up.
- Widths: the baud counter is $clog2(CLKS_PER_BIT) bits, with a minimum of 1. The bit counter is $clog2(FRAME_W) bits. Neither counter may wrap outside its stated range.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_W = 12;
  - field positions START_POS = 11, DATA_MSB = 10, DATA_LSB = 3, PAR_POS = 2, STOP_MSB = 1, STOP_LSB = 0;
  - state enum {IDLE, SHIFT};
  - DEFAULT_CLKS_PER_BIT = 16.
- One sub-module, uart_baud_cnt:
  - parameter CLKS_PER_BIT; inputs clk, rst, en; output bit_tick;
  - clears the count when en = 0.
  - Reused later by the receiver.

Test Plan:
1. CLKS_PER_BIT = 4, reset then idle 10 cycles -> tx = 1, frame_ready = 1, busy = 0, done = 0 throughout.
2. CLKS_PER_BIT = 4, frame_in = 12'hD28 (start = 1, data = 8'hA5, parity = 0, stop = 2'b00), single-cycle valid at E0:
   - tx = 1,1,0,1,0,0,1,0,1,0,0,0, each bit held exactly 4 cycles;
   - done pulses once at E0+48; frame_ready returns to 1 at E0+48.
3. frame_valid held high with frames 12'hD28 then 12'h9FC:
   - second accept at E0+49; exactly one idle-high cycle between frames;
   - second frame bit sequence is correct.
4. During SHIFT, change frame_in to 12'hFFF and pulse frame_valid -> transmitted bits still match 12'hD28; no extra accept; frame_ready stays 0.
5. Assert rst at E0+17 (mid data bit) -> tx = 1 asynchronously, busy = 0, no done pulse; a new 12'h800 sent after release is serialised correctly.
6. CLKS_PER_BIT = 1, frame 12'hAAA -> tx toggles 1,0,1,0... each cycle for 12 cycles; done at E0+12.
